// File: rtl/pwm_carrier_gen.sv
// Shared PWM carrier counter: up/down sawtooth or triangle, prescaled, shadowed.
// Optional macro CARRIER_SYNC_EN enables sync_in resync of count, prescaler and dir.
module pwm_carrier_gen #(
    parameter int PWMCOUNT_WIDTH = 16,
    parameter int DIVCLK_WIDTH   = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      pwm_onoff,
    input  logic [1:0]                carr_mode,
    input  logic [PWMCOUNT_WIDTH-1:0] period,
    input  logic [PWMCOUNT_WIDTH-1:0] init_phase,
    input  logic [DIVCLK_WIDTH-1:0]   clkdiv,
    input  logic [1:0]                mask_sel,
    input  logic                      sync_in,
    output logic [PWMCOUNT_WIDTH-1:0] carrier,
    output logic                      dir,
    output logic                      zero_evt,
    output logic                      peak_evt,
    output logic                      maskevent
);

    localparam logic [1:0] MODE_UP = 2'b00;
    localparam logic [1:0] MODE_DN = 2'b01;

    typedef enum logic [1:0] {S_OFF, S_START, S_RUN} state_t;

    state_t                    state_q, state_d;
    logic [PWMCOUNT_WIDTH-1:0] carrier_q, carrier_d;
    logic                      dir_q, dir_d;
    logic                      zero_q, zero_d;
    logic                      peak_q, peak_d;
    logic                      mask_q, mask_d;
    logic [DIVCLK_WIDTH-1:0]   presc_q, presc_d;
    logic [PWMCOUNT_WIDTH-1:0] per_sh_q, per_sh_d;
    logic [1:0]                mode_sh_q, mode_sh_d;
    logic [DIVCLK_WIDTH-1:0]   div_sh_q, div_sh_d;
    logic [1:0]                msel_sh_q, msel_sh_d;

    logic [PWMCOUNT_WIDTH-1:0] phase_in, phase_sh, step_val, peak_ref;
    logic                      step_dir, wrap, go_down, tick, sync_act;

    assign carrier   = carrier_q;
    assign dir       = dir_q;
    assign zero_evt  = zero_q;
    assign peak_evt  = peak_q;
    assign maskevent = mask_q;

`ifdef CARRIER_SYNC_EN
    assign sync_act = sync_in;
`else
    assign sync_act = sync_in & 1'b0;
`endif

    assign phase_in = (init_phase > period)   ? period   : init_phase;
    assign phase_sh = (init_phase > per_sh_q) ? per_sh_q : init_phase;
    assign tick     = (presc_q == div_sh_q);

    function automatic logic sel_mask(input logic z, input logic p,
                                      input logic [1:0] s);
        return (s == 2'b00) ? z : (s == 2'b01) ? p : (z | p);
    endfunction

    // Next count/direction on a tick; wrap marks return to cycle start.
    always_comb begin
        step_val = carrier_q;
        step_dir = dir_q;
        wrap     = 1'b0;
        go_down  = 1'b0;
        peak_ref = per_sh_q;
        if (mode_sh_q == MODE_UP) begin
            step_dir = 1'b0;
            if (carrier_q >= per_sh_q) begin
                step_val = '0;
                wrap     = 1'b1;
            end else begin
                step_val = carrier_q + 1'b1;
            end
        end else if (mode_sh_q == MODE_DN) begin
            step_dir = 1'b1;
            if (carrier_q == '0) begin
                // Down cycle restarts at the newly latched period.
                step_val = period;
                peak_ref = period;
                wrap     = 1'b1;
            end else if (carrier_q > per_sh_q) begin
                step_val = per_sh_q;
            end else begin
                step_val = carrier_q - 1'b1;
            end
        end else if (per_sh_q == '0) begin
            step_val = '0;
            step_dir = 1'b0;
            wrap     = 1'b1;
        end else begin
            go_down = dir_q ? (carrier_q != '0) : (carrier_q >= per_sh_q);
            if (go_down) begin
                step_val = (carrier_q > per_sh_q) ? per_sh_q - 1'b1
                                                  : carrier_q - 1'b1;
                step_dir = (step_val != '0);
                wrap     = (step_val == '0);
            end else begin
                step_val = carrier_q + 1'b1;
                step_dir = (step_val == per_sh_q);
            end
        end
    end

    // Control FSM: start/stop, sync, ticked count update and shadow loads.
    always_comb begin
        state_d   = state_q;
        carrier_d = carrier_q;
        dir_d     = dir_q;
        zero_d    = 1'b0;
        peak_d    = 1'b0;
        mask_d    = 1'b0;
        presc_d   = presc_q;
        per_sh_d  = per_sh_q;
        mode_sh_d = mode_sh_q;
        div_sh_d  = div_sh_q;
        msel_sh_d = msel_sh_q;
        unique case (state_q)
            S_OFF: begin
                carrier_d = '0;
                dir_d     = 1'b0;
                presc_d   = '0;
                if (pwm_onoff) begin
                    state_d   = S_START;
                    per_sh_d  = period;
                    mode_sh_d = carr_mode;
                    div_sh_d  = clkdiv;
                    msel_sh_d = mask_sel;
                    carrier_d = phase_in;
                    dir_d     = (carr_mode == MODE_DN);
                    zero_d    = (phase_in == '0);
                    peak_d    = (phase_in == period);
                    mask_d    = 1'b1;
                end
            end
            S_START, S_RUN: begin
                state_d = S_RUN;
                if (!pwm_onoff) begin
                    state_d   = S_OFF;
                    carrier_d = '0;
                    dir_d     = 1'b0;
                    presc_d   = '0;
                end else if (sync_act) begin
                    carrier_d = phase_sh;
                    dir_d     = (mode_sh_q == MODE_DN);
                    presc_d   = '0;
                    zero_d    = (phase_sh == '0);
                    peak_d    = (phase_sh == per_sh_q);
                    mask_d    = sel_mask(zero_d, peak_d, msel_sh_q);
                end else if (tick) begin
                    presc_d   = '0;
                    carrier_d = step_val;
                    dir_d     = wrap ? (carr_mode == MODE_DN) : step_dir;
                    zero_d    = (step_val == '0);
                    peak_d    = (step_val == peak_ref);
                    mask_d    = sel_mask(zero_d, peak_d, msel_sh_q);
                    if (wrap) begin
                        per_sh_d  = period;
                        mode_sh_d = carr_mode;
                        div_sh_d  = clkdiv;
                        msel_sh_d = mask_sel;
                    end
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            default: state_d = S_OFF;
        endcase
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_OFF;
            carrier_q <= '0;
            dir_q     <= 1'b0;
            zero_q    <= 1'b0;
            peak_q    <= 1'b0;
            mask_q    <= 1'b0;
            presc_q   <= '0;
            per_sh_q  <= '0;
            mode_sh_q <= '0;
            div_sh_q  <= '0;
            msel_sh_q <= '0;
        end else begin
            state_q   <= state_d;
            carrier_q <= carrier_d;
            dir_q     <= dir_d;
            zero_q    <= zero_d;
            peak_q    <= peak_d;
            mask_q    <= mask_d;
            presc_q   <= presc_d;
            per_sh_q  <= per_sh_d;
            mode_sh_q <= mode_sh_d;
            div_sh_q  <= div_sh_d;
            msel_sh_q <= msel_sh_d;
        end
    end

endmodule

// File: tb/tb_pwm_carrier_gen.sv
// Scoreboard bench for pwm_carrier_gen.
// Expected outputs are queued at stimulus time and popped after each edge.
module tb_pwm_carrier_gen;
    localparam int CW = 16;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          pwm_onoff = 1'b0;
    logic          sync_in = 1'b0;
    logic [1:0]    carr_mode = 2'b00;
    logic [1:0]    mask_sel = 2'b00;
    logic [CW-1:0] period = '0;
    logic [CW-1:0] init_phase = '0;
    logic [DW-1:0] clkdiv = '0;
    logic [CW-1:0] carrier;
    logic          dir, zero_evt, peak_evt, maskevent;

    typedef struct packed {
        logic [CW-1:0] c;
        logic          d;
        logic          z;
        logic          p;
        logic          m;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    pwm_carrier_gen #(.PWMCOUNT_WIDTH(CW), .DIVCLK_WIDTH(DW)) dut (
        .clk(clk), .reset(reset), .pwm_onoff(pwm_onoff),
        .carr_mode(carr_mode), .period(period), .init_phase(init_phase),
        .clkdiv(clkdiv), .mask_sel(mask_sel), .sync_in(sync_in),
        .carrier(carrier), .dir(dir), .zero_evt(zero_evt),
        .peak_evt(peak_evt), .maskevent(maskevent)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic msk(input logic z, input logic p, input logic [1:0] s);
        return (s == 2'b00) ? z : (s == 2'b01) ? p : (z | p);
    endfunction

    always @(posedge clk) begin : mon
        exp_t e;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_val("carrier", 32'(carrier), 32'(e.c));
            check_val("dir", 32'(dir), 32'(e.d));
            check_val("zero_evt", 32'(zero_evt), 32'(e.z));
            check_val("peak_evt", 32'(peak_evt), 32'(e.p));
            check_val("maskevent", 32'(maskevent), 32'(e.m));
        end
    end

    task automatic step(input logic [CW-1:0] c, input logic d, input logic z,
                        input logic p, input logic m);
        exp_t e;
        e = '{c: c, d: d, z: z, p: p, m: m};
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic stop_run();
        pwm_onoff = 1'b0;
        step('0, 1'b0, 1'b0, 1'b0, 1'b0);
        step('0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic run_pat(input logic [1:0] mode, input int P, input int div,
                           input logic [1:0] sel, input int ncyc);
        int   vals[$];
        logic dirs[$];
        logic z, p;
        if (mode == 2'b00) begin
            for (int k = 0; k <= P; k++)
                for (int r = 0; r <= div; r++) begin vals.push_back(k); dirs.push_back(1'b0); end
        end else if (mode == 2'b01) begin
            for (int k = P; k >= 0; k--)
                for (int r = 0; r <= div; r++) begin vals.push_back(k); dirs.push_back(1'b1); end
        end else begin
            for (int k = 0; k < P; k++)
                for (int r = 0; r <= div; r++) begin vals.push_back(k); dirs.push_back(1'b0); end
            for (int k = P; k > 0; k--)
                for (int r = 0; r <= div; r++) begin vals.push_back(k); dirs.push_back(1'b1); end
        end
        carr_mode  = mode;
        period     = CW'(P);
        clkdiv     = DW'(div);
        mask_sel   = sel;
        init_phase = (mode == 2'b01) ? CW'(P + 3) : '0;
        pwm_onoff  = 1'b1;
        for (int c = 0; c < ncyc; c++) begin
            int   i;
            logic first;
            i     = c % vals.size();
            first = ((i % (div + 1)) == 0);
            z     = first && (vals[i] == P);
            p     = z;
            z     = first && (vals[i] == 0);
            step(CW'(vals[i]), dirs[i], z, p, (c == 0) ? 1'b1 : msk(z, p, sel));
        end
    endtask

    initial begin
        #2;
        check_val("rst_carrier", 32'(carrier), 0);
        check_val("rst_dir", 32'(dir), 0);
        check_val("rst_zero", 32'(zero_evt), 0);
        check_val("rst_peak", 32'(peak_evt), 0);
        check_val("rst_mask", 32'(maskevent), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        step('0, 1'b0, 1'b0, 1'b0, 1'b0);

        // up saw, then triangle with prescale, down saw, zero period
        run_pat(2'b00, 4, 0, 2'b00, 12);
        stop_run();
        run_pat(2'b10, 3, 1, 2'b10, 28);
        stop_run();
        run_pat(2'b01, 3, 0, 2'b01, 10);
        stop_run();
        run_pat(2'b00, 0, 2, 2'b00, 7);
        stop_run();

        // period change mid-cycle takes effect only at the next cycle start
        carr_mode = 2'b00; period = 16'd4; clkdiv = '0; mask_sel = 2'b01;
        init_phase = '0; pwm_onoff = 1'b1;
        step(16'd0, 0, 1, 0, 1);
        step(16'd1, 0, 0, 0, 0);
        period = 16'd2;
        step(16'd2, 0, 0, 0, 0);
        step(16'd3, 0, 0, 0, 0);
        step(16'd4, 0, 0, 1, 1);
        step(16'd0, 0, 1, 0, 0);
        step(16'd1, 0, 0, 0, 0);
        step(16'd2, 0, 0, 1, 1);
        step(16'd0, 0, 1, 0, 0);
        step(16'd1, 0, 0, 0, 0);
        step(16'd2, 0, 0, 1, 1);
        stop_run();

        // restart with phase above period: clamped, single mask pulse
        period = 16'd5; init_phase = 16'd7; mask_sel = 2'b01; pwm_onoff = 1'b1;
        step(16'd5, 0, 0, 1, 1);
        step(16'd0, 0, 1, 0, 0);
        step(16'd1, 0, 0, 0, 0);
        step(16'd2, 0, 0, 0, 0);
        step(16'd3, 0, 0, 0, 0);
        step(16'd4, 0, 0, 0, 0);
        step(16'd5, 0, 0, 1, 1);
        stop_run();

        // asynchronous reset mid-count
        period = 16'd9; init_phase = '0; mask_sel = 2'b00; pwm_onoff = 1'b1;
        step(16'd0, 0, 1, 0, 1);
        step(16'd1, 0, 0, 0, 0);
        step(16'd2, 0, 0, 0, 0);
        step(16'd3, 0, 0, 0, 0);
        reset = 1'b0;
        #1;
        check_val("arst_carrier", 32'(carrier), 0);
        check_val("arst_dir", 32'(dir), 0);
        check_val("arst_mask", 32'(maskevent), 0);
        @(negedge clk);
        reset = 1'b1;
        init_phase = 16'd2;
        step(16'd2, 0, 0, 0, 1);
        step(16'd3, 0, 0, 0, 0);
        step(16'd4, 0, 0, 0, 0);
        stop_run();

        // sync pulse at carrier 6
        period = 16'd9; init_phase = 16'd2; pwm_onoff = 1'b1;
        step(16'd2, 0, 0, 0, 1);
        step(16'd3, 0, 0, 0, 0);
        step(16'd4, 0, 0, 0, 0);
        step(16'd5, 0, 0, 0, 0);
        step(16'd6, 0, 0, 0, 0);
        sync_in = 1'b1;
`ifdef CARRIER_SYNC_EN
        step(16'd2, 0, 0, 0, 0);
        sync_in = 1'b0;
        step(16'd3, 0, 0, 0, 0);
`else
        step(16'd7, 0, 0, 0, 0);
        sync_in = 1'b0;
        step(16'd8, 0, 0, 0, 0);
`endif
        stop_run();

        @(negedge clk);
        check_val("sb_empty", 32'(sb_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
